// File: rtl/bhr_ckpt.sv
`default_nettype none
// ============================================================================
// Module   : bhr_ckpt
// Purpose  : Speculative global branch-history register with a circular
//            checkpoint buffer. Fetch shifts predicted directions into the
//            speculative history and saves the pre-prediction history per
//            branch; execute mispredicts restore from the checkpoint; retire
//            advances the architectural history; flush copies it back.
// Revision : 1.0 - initial release
// ============================================================================
module bhr_ckpt #(
    parameter int DEPTH = 8,
    parameter int CKPTS = 8,
    localparam int CW   = $clog2(CKPTS)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             pred_valid,
    input  logic             pred_taken,
    output logic             pred_ready,
    output logic [CW-1:0]    pred_tag,
    output logic [DEPTH-1:0] pred_bhr,
    input  logic             resolve_valid,
    input  logic [CW-1:0]    resolve_tag,
    input  logic             resolve_mispredict,
    input  logic             resolve_taken,
    input  logic             retire_valid,
    input  logic             retire_taken,
    input  logic             flush,
    output logic [DEPTH-1:0] spec_bhr,
    output logic [DEPTH-1:0] arch_bhr,
    output logic [CW:0]      count,
    output logic             full,
    output logic             empty
);

    localparam logic [CW:0]   C_CNT_FULL = (CW+1)'(CKPTS);
    localparam logic [CW:0]   C_CNT_ONE  = (CW+1)'(1);
    localparam logic [CW-1:0] C_PTR_ONE  = CW'(1);

    logic [DEPTH-1:0] spec_q, spec_d;
    logic [DEPTH-1:0] arch_q, arch_d;
    logic [DEPTH-1:0] ckpt_q [CKPTS];
    logic [DEPTH-1:0] ckpt_d [CKPTS];
    logic [CW-1:0]    head_q, head_d;
    logic [CW-1:0]    tail_q, tail_d;
    logic [CW:0]      count_q, count_d;

    logic             w_full;
    logic             w_empty;
    logic             w_retire;
    logic [CW-1:0]    w_off;
    logic             w_live;
    logic             w_mispredict;
    logic             w_pred_ok;
    logic [CW:0]      w_span;
    logic [CW:0]      w_ret_dec;

    // Occupancy flags, resolve-tag liveness and the arbitration terms.
    // A tag is live when its distance from head is below the occupancy;
    // with count == CKPTS every slot is live.
    always_comb begin
        w_full       = (count_q == C_CNT_FULL);
        w_empty      = (count_q == '0);
        w_retire     = retire_valid && !w_empty;
        w_off        = resolve_tag - head_q;
        w_live       = !w_empty && ({1'b0, w_off} < count_q);
        w_mispredict = resolve_valid && resolve_mispredict && w_live;
        w_pred_ok    = !w_full && !flush && !w_mispredict;
        // Distance head..tag inclusive; the extra bit turns a wrapped 0 into CKPTS.
        w_span       = {1'b0, w_off} + C_CNT_ONE;
        w_ret_dec    = {{CW{1'b0}}, w_retire};
    end

    // Next-state computation: retire is independent, then flush > mispredict > prediction.
    always_comb begin
        arch_d  = arch_q;
        head_d  = head_q;
        spec_d  = spec_q;
        tail_d  = tail_q;
        count_d = count_q - w_ret_dec;
        for (int i = 0; i < CKPTS; i++) begin
            ckpt_d[i] = ckpt_q[i];
        end

        if (w_retire) begin
            arch_d = DEPTH'({arch_q, retire_taken});
            head_d = head_q + C_PTR_ONE;
        end

        if (flush) begin
            spec_d  = arch_d;
            tail_d  = head_d;
            count_d = '0;
        end else if (w_mispredict) begin
            // Youngest surviving branch is the mispredicting one; everything after it is freed.
            spec_d  = DEPTH'({ckpt_q[resolve_tag], resolve_taken});
            tail_d  = resolve_tag + C_PTR_ONE;
            count_d = w_span - w_ret_dec;
        end else if (pred_valid && w_pred_ok) begin
            ckpt_d[tail_q] = spec_q;
            spec_d         = DEPTH'({spec_q, pred_taken});
            tail_d         = tail_q + C_PTR_ONE;
            count_d        = count_q + C_CNT_ONE - w_ret_dec;
        end
    end

    // State registers with asynchronous clear of history, pointers and checkpoints.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            spec_q  <= '0;
            arch_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < CKPTS; i++) begin
                ckpt_q[i] <= '0;
            end
        end else begin
            spec_q  <= spec_d;
            arch_q  <= arch_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            for (int i = 0; i < CKPTS; i++) begin
                ckpt_q[i] <= ckpt_d[i];
            end
        end
    end

    // Output mapping; pred_ready depends only on state, flush and resolve inputs.
    always_comb begin
        pred_ready = w_pred_ok;
        pred_tag   = tail_q;
        pred_bhr   = spec_q;
        spec_bhr   = spec_q;
        arch_bhr   = arch_q;
        count      = count_q;
        full       = w_full;
        empty      = w_empty;
    end

endmodule
`default_nettype wire

// File: tb/tb_bhr_ckpt.sv
`default_nettype none
// ============================================================================
// Module   : tb_bhr_ckpt
// Purpose  : Directed bench for bhr_ckpt (DEPTH=4, CKPTS=4) with
//            hand-computed expected values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bhr_ckpt;

    localparam int DEPTH = 4;
    localparam int CKPTS = 4;
    localparam int CW    = 2;

    logic             clock;
    logic             reset;
    logic             pred_valid;
    logic             pred_taken;
    logic             pred_ready;
    logic [CW-1:0]    pred_tag;
    logic [DEPTH-1:0] pred_bhr;
    logic             resolve_valid;
    logic [CW-1:0]    resolve_tag;
    logic             resolve_mispredict;
    logic             resolve_taken;
    logic             retire_valid;
    logic             retire_taken;
    logic             flush;
    logic [DEPTH-1:0] spec_bhr;
    logic [DEPTH-1:0] arch_bhr;
    logic [CW:0]      count;
    logic             full;
    logic             empty;

    int n_total = 0;
    int n_bad   = 0;

    bhr_ckpt #(.DEPTH(DEPTH), .CKPTS(CKPTS)) u_dut (
        .clock              (clock),
        .reset              (reset),
        .pred_valid         (pred_valid),
        .pred_taken         (pred_taken),
        .pred_ready         (pred_ready),
        .pred_tag           (pred_tag),
        .pred_bhr           (pred_bhr),
        .resolve_valid      (resolve_valid),
        .resolve_tag        (resolve_tag),
        .resolve_mispredict (resolve_mispredict),
        .resolve_taken      (resolve_taken),
        .retire_valid       (retire_valid),
        .retire_taken       (retire_taken),
        .flush              (flush),
        .spec_bhr           (spec_bhr),
        .arch_bhr           (arch_bhr),
        .count              (count),
        .full               (full),
        .empty              (empty)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        pred_valid         = 1'b0;
        pred_taken         = 1'b0;
        resolve_valid      = 1'b0;
        resolve_tag        = '0;
        resolve_mispredict = 1'b0;
        resolve_taken      = 1'b0;
        retire_valid       = 1'b0;
        retire_taken       = 1'b0;
        flush              = 1'b0;
    endtask

    // Advance one clock; inputs were set at the previous falling edge, outputs sampled at the next.
    task automatic step();
        @(posedge clock);
        @(negedge clock);
        idle();
    endtask

    task automatic predict(input logic t);
        pred_valid = 1'b1;
        pred_taken = t;
        step();
    endtask

    task automatic retire(input logic t);
        retire_valid = 1'b1;
        retire_taken = t;
        step();
    endtask

    initial begin
        idle();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        // Reset values
        chk("rst_spec",  32'(spec_bhr),   32'h0);
        chk("rst_arch",  32'(arch_bhr),   32'h0);
        chk("rst_count", 32'(count),      32'h0);
        chk("rst_empty", 32'(empty),      32'h1);
        chk("rst_full",  32'(full),       32'h0);
        chk("rst_ready", 32'(pred_ready), 32'h1);
        chk("rst_tag",   32'(pred_tag),   32'h0);
        chk("rst_bhr",   32'(pred_bhr),   32'h0);
        reset = 1'b0;
        @(negedge clock);

        // Predict T, N, T
        chk("p1_tag", 32'(pred_tag), 32'h0);
        predict(1'b1);
        chk("p1_spec", 32'(spec_bhr), 32'h1);
        chk("p2_tag", 32'(pred_tag), 32'h1);
        predict(1'b0);
        chk("p2_spec", 32'(spec_bhr), 32'h2);
        chk("p3_tag", 32'(pred_tag), 32'h2);
        predict(1'b1);
        chk("p3_spec", 32'(spec_bhr), 32'h5);
        chk("p3_count", 32'(count), 32'h3);

        // Mispredict tag 1 (taken) with a competing prediction in the same cycle
        resolve_valid      = 1'b1;
        resolve_tag        = 2'd1;
        resolve_mispredict = 1'b1;
        resolve_taken      = 1'b1;
        pred_valid         = 1'b1;
        pred_taken         = 1'b0;
        #1;
        chk("mp_ready", 32'(pred_ready), 32'h0);
        step();
        chk("mp_spec",  32'(spec_bhr), 32'h3);
        chk("mp_count", 32'(count),    32'h2);
        chk("mp_tag",   32'(pred_tag), 32'h2);
        chk("mp_arch",  32'(arch_bhr), 32'h0);

        // Fill to 4 slots: 0011 -> 0111 -> 1111
        predict(1'b1);
        predict(1'b1);
        chk("fill_spec",  32'(spec_bhr),   32'hf);
        chk("fill_count", 32'(count),      32'h4);
        chk("fill_full",  32'(full),       32'h1);
        chk("fill_ready", 32'(pred_ready), 32'h0);
        predict(1'b0);
        chk("ovf_spec",  32'(spec_bhr), 32'hf);
        chk("ovf_count", 32'(count),    32'h4);
        retire(1'b1);
        chk("ret_arch",  32'(arch_bhr),   32'h1);
        chk("ret_count", 32'(count),      32'h3);
        chk("ret_ready", 32'(pred_ready), 32'h1);
        chk("wrap_tag",  32'(pred_tag),   32'h0);
        predict(1'b0);
        chk("wrap_spec",  32'(spec_bhr), 32'he);
        chk("wrap_count", 32'(count),    32'h4);

        // Mispredict across the wrap: head=1, tag 3 holds 0111
        resolve_valid      = 1'b1;
        resolve_tag        = 2'd3;
        resolve_mispredict = 1'b1;
        resolve_taken      = 1'b1;
        step();
        chk("mpw_spec",  32'(spec_bhr), 32'hf);
        chk("mpw_count", 32'(count),    32'h3);
        chk("mpw_tag",   32'(pred_tag), 32'h0);

        // Mispredict on a non-live tag (head=1, tail=0): ignored
        resolve_valid      = 1'b1;
        resolve_tag        = 2'd0;
        resolve_mispredict = 1'b1;
        resolve_taken      = 1'b0;
        #1;
        chk("nl_ready", 32'(pred_ready), 32'h1);
        step();
        chk("nl_spec",  32'(spec_bhr), 32'hf);
        chk("nl_count", 32'(count),    32'h3);

        // Mispredict the retiring head (tag 1 holds 0001)
        resolve_valid      = 1'b1;
        resolve_tag        = 2'd1;
        resolve_mispredict = 1'b1;
        resolve_taken      = 1'b0;
        retire_valid       = 1'b1;
        retire_taken       = 1'b1;
        step();
        chk("mh_spec",  32'(spec_bhr), 32'h2);
        chk("mh_arch",  32'(arch_bhr), 32'h3);
        chk("mh_count", 32'(count),    32'h0);
        chk("mh_empty", 32'(empty),    32'h1);
        chk("mh_tag",   32'(pred_tag), 32'h2);

        // Retire on an empty buffer is ignored
        retire(1'b0);
        chk("re_arch",  32'(arch_bhr), 32'h3);
        chk("re_count", 32'(count),    32'h0);

        // Fresh start for the flush scenario
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        predict(1'b1);
        predict(1'b0);
        predict(1'b1);
        retire(1'b1);
        retire(1'b0);
        chk("fl_pre_arch", 32'(arch_bhr), 32'h2);
        flush        = 1'b1;
        retire_valid = 1'b1;
        retire_taken = 1'b1;
        pred_valid   = 1'b1;
        #1;
        chk("fl_ready", 32'(pred_ready), 32'h0);
        step();
        chk("fl_arch",  32'(arch_bhr), 32'h5);
        chk("fl_spec",  32'(spec_bhr), 32'h5);
        chk("fl_count", 32'(count),    32'h0);
        chk("fl_empty", 32'(empty),    32'h1);
        chk("fl_tag",   32'(pred_tag), 32'h3);

        // Build count=3 (tags 3,0,1), then reset between edges
        predict(1'b1);
        predict(1'b0);
        predict(1'b1);
        chk("ar_pre_spec",  32'(spec_bhr), 32'hd);
        chk("ar_pre_count", 32'(count),    32'h3);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_spec",  32'(spec_bhr),   32'h0);
        chk("ar_arch",  32'(arch_bhr),   32'h0);
        chk("ar_count", 32'(count),      32'h0);
        chk("ar_empty", 32'(empty),      32'h1);
        chk("ar_tag",   32'(pred_tag),   32'h0);
        chk("ar_ready", 32'(pred_ready), 32'h1);
        reset = 1'b0;
        @(negedge clock);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
